// File: rtl/alu_seq_core.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative
// unsigned shift-add multiply and restoring divide, on valid/ready channels.
module alu_seq_core #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [3:0]       flags,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpNot = 4'd5;
  localparam logic [3:0] OpShl = 4'd6;
  localparam logic [3:0] OpShr = 4'd7;
  localparam logic [3:0] OpSar = 4'd8;
  localparam logic [3:0] OpMul = 4'd9;
  localparam logic [3:0] OpDiv = 4'd10;
  localparam logic [3:0] OpCmp = 4'd11;

  state_e           state_q, state_d;
  logic             is_mul_q, is_mul_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  // Single-cycle datapath, evaluated on the accept cycle
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_full, sub_full, shl_full, shr_full;
  logic [WIDTH-1:0] r_lo, r_hi;
  logic             r_c, r_v, r_err, r_rsv;
  logic [3:0]       r_flags;

  // Iteration datapath
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    sh       = b[SHW-1:0];
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} - {1'b0, b};
    // Extra bit on the far side of each shift catches the last bit shifted out
    shl_full = {1'b0, a} << sh;
    shr_full = {a, 1'b0} >> sh;
    r_lo     = '0;
    r_hi     = '0;
    r_c      = 1'b0;
    r_v      = 1'b0;
    r_err    = 1'b0;
    r_rsv    = 1'b0;
    case (op)
      OpAdd: begin
        r_lo = add_full[WIDTH-1:0];
        r_c  = add_full[WIDTH];
        r_v  = (a[WIDTH-1] == b[WIDTH-1]) && (r_lo[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub, OpCmp: begin
        r_lo = sub_full[WIDTH-1:0];
        r_c  = sub_full[WIDTH];
        r_v  = (a[WIDTH-1] != b[WIDTH-1]) && (r_lo[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd: r_lo = a & b;
      OpOr:  r_lo = a | b;
      OpXor: r_lo = a ^ b;
      OpNot: r_lo = ~a;
      OpShl: begin
        r_lo = shl_full[WIDTH-1:0];
        r_c  = shl_full[WIDTH];
      end
      OpShr: begin
        r_lo = shr_full[WIDTH:1];
        r_c  = shr_full[0];
      end
      OpSar: r_lo = $unsigned($signed(a) >>> sh);
      OpMul: ;
      OpDiv: begin
        // Only reached here with a zero divisor
        r_lo  = '1;
        r_hi  = a;
        r_err = 1'b1;
      end
      default: begin
        r_err = 1'b1;
        r_rsv = 1'b1;
      end
    endcase
    r_flags = r_rsv ? 4'b0000 : {r_v, r_c, r_lo[WIDTH-1], r_lo == '0};
    if (op == OpCmp) r_lo = '0;
  end

  always_comb begin
    mul_sum  = {1'b0, res_hi_q} + (res_lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {res_hi_q, res_lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_ge   = div_sh >= {1'b0, b_q};
    if (is_mul_q) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], res_lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      step_lo = {res_lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d  = state_q;
    is_mul_d = is_mul_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          is_mul_d = (op == OpMul);
          b_d      = b;
          cnt_d    = '0;
          if (op == OpMul || (op == OpDiv && b != '0)) begin
            // hi:lo doubles as product/multiplier or remainder/quotient
            state_d  = StExec;
            res_hi_d = '0;
            res_lo_d = a;
            flags_d  = '0;
            err_d    = 1'b0;
          end else begin
            state_d  = StDone;
            res_lo_d = r_lo;
            res_hi_d = r_hi;
            flags_d  = r_flags;
            err_d    = r_err;
          end
        end
      end
      StExec: begin
        res_hi_d = step_hi;
        res_lo_d = step_lo;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = StDone;
          if (is_mul_q) begin
            flags_d = {1'b0, step_hi != '0, step_hi[WIDTH-1], {step_hi, step_lo} == '0};
          end else begin
            flags_d = {1'b0, 1'b0, step_lo[WIDTH-1], step_lo == '0};
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      is_mul_q <= 1'b0;
      b_q      <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_mul_q <= is_mul_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign res_lo    = res_lo_q;
  assign res_hi    = res_hi_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core at WIDTH=8: reference model results are
// queued at accept and compared, with latency, when the result appears.
module tb_alu_seq_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = 4'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] res_lo, res_hi;
  logic [3:0] flags;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] flags;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb_q[$];

  alu_seq_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_lo    (res_lo),
    .res_hi    (res_hi),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input int o, input int x, input int y);
    exp_t e;
    int   r, sx, sy, n, p;
    logic c, v;
    sx = (x > 127) ? x - 256 : x;
    sy = (y > 127) ? y - 256 : y;
    n  = y % 8;
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    e.hi  = 8'h00;
    e.err = 1'b0;
    e.lat = 1;
    case (o)
      0: begin
        r = x + y;
        c = (r > 255);
        v = (sx + sy > 127) || (sx + sy < -128);
      end
      1, 11: begin
        r = x - y;
        c = (x < y);
        v = (sx - sy > 127) || (sx - sy < -128);
      end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = 255 - x;
      6: begin
        r = x << n;
        c = (n != 0) && (((x >> (8 - n)) & 1) != 0);
      end
      7: begin
        r = x >> n;
        c = (n != 0) && (((x >> (n - 1)) & 1) != 0);
      end
      8: r = sx >>> n;
      9: begin
        p = x * y;
        e.lo = 8'(p);
        e.hi = 8'(p >> 8);
        e.flags = {1'b0, e.hi != 8'h00, e.hi[7], p == 0};
        e.lat = 9;
        return e;
      end
      10: begin
        if (y == 0) begin
          e.lo = 8'hFF;
          e.hi = 8'(x);
          e.err = 1'b1;
          e.flags = 4'b0010;
        end else begin
          e.lo = 8'(x / y);
          e.hi = 8'(x % y);
          e.flags = {2'b00, e.lo[7], e.lo == 8'h00};
          e.lat = 9;
        end
        return e;
      end
      default: begin
        e.lo = 8'h00;
        e.err = 1'b1;
        e.flags = 4'b0000;
        return e;
      end
    endcase
    e.lo = 8'(r);
    e.flags = {v, c, e.lo[7], e.lo == 8'h00};
    if (o == 11) e.lo = 8'h00;
    return e;
  endfunction

  // Drive one op, wait for its result, hold it for `hold` cycles, then release it
  task automatic do_op(input string tag, input int o, input int x, input int y, input int hold);
    exp_t e;
    int   lat;
    logic ir_bad;
    logic [7:0] lo0;
    @(negedge clk);
    check_eq({tag, " in_ready idle"}, in_ready, 1'b1);
    op = 4'(o);
    a = 8'(x);
    b = 8'(y);
    in_valid = 1'b1;
    out_ready = 1'b0;
    sb_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15));
    a = 8'($urandom);
    b = 8'($urandom);
    lat = 1;
    ir_bad = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      ir_bad |= in_ready;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    check_eq({tag, " latency"}, lat, e.lat);
    check_eq({tag, " in_ready busy"}, ir_bad, 1'b0);
    check_eq({tag, " res_lo"}, res_lo, e.lo);
    check_eq({tag, " res_hi"}, res_hi, e.hi);
    check_eq({tag, " flags"}, flags, e.flags);
    check_eq({tag, " err"}, err, e.err);
    if (hold > 0) begin
      lo0 = res_lo;
      repeat (hold) @(negedge clk);
      check_eq({tag, " held valid"}, out_valid, 1'b1);
      check_eq({tag, " held in_ready"}, in_ready, 1'b0);
      check_eq({tag, " held res_lo"}, res_lo, lo0);
      check_eq({tag, " held flags"}, flags, e.flags);
      check_eq({tag, " held err"}, err, e.err);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, " out_valid drop"}, out_valid, 1'b0);
    check_eq({tag, " in_ready back"}, in_ready, 1'b1);
  endtask

  initial begin
    int amts[3];
    amts = '{0, 1, 7};
    #1;
    check_eq("reset out_valid", out_valid, 1'b0);
    check_eq("reset in_ready", in_ready, 1'b1);
    check_eq("reset res", {res_hi, res_lo}, 16'h0000);
    check_eq("reset flags", flags, 4'h0);
    check_eq("reset err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    do_op("T1 add", 0, 8'hFF, 8'h01, 0);
    do_op("T2 sub", 1, 8'h80, 8'h01, 0);
    do_op("T2 cmp", 11, 8'h03, 8'h05, 0);
    do_op("T3 mul", 9, 8'hFF, 8'hFF, 0);
    do_op("T4 div", 10, 200, 7, 0);
    do_op("T4 div0", 10, 8'hC8, 0, 0);
    do_op("T5 add hold", 0, 8'h12, 8'h34, 5);

    // Abort a MUL with reset four cycles in
    @(negedge clk);
    op = 4'd9;
    a = 8'hFF;
    b = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("T6 rst out_valid", out_valid, 1'b0);
    check_eq("T6 rst in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    do_op("T6 add after rst", 0, 8'h70, 8'h10, 0);

    for (int s = 6; s <= 8; s++) begin
      for (int k = 0; k < 3; k++) begin
        do_op($sformatf("shift op%0d by %0d", s, amts[k]), s, 8'hB5, 8'hA8 | amts[k], 0);
        do_op($sformatf("shift op%0d by %0d b", s, amts[k]), s, 8'h4C, 8'hA8 | amts[k], 0);
      end
    end
    do_op("rsv op13", 13, 8'h55, 8'hAA, 0);
    do_op("not", 5, 8'h0F, 8'h00, 0);
    do_op("mul zero", 9, 8'h00, 8'h37, 2);

    for (int i = 0; i < 16; i++) begin
      int ro, ra, rb;
      ro = $urandom_range(0, 15);
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      if (ro == 10 && (i % 4) == 0) rb = 0;
      do_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, i % 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
